// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared helpers for the multi-channel button debouncer.
//   cnt_width(): number of bits needed to hold values 0..max_val (never 0)
//   EV_*       : bit positions of the per-channel event vector
package debounce_pkg;

  // Bits needed to count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Event vector layout shared by debounce_channel and debounce_multi.
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_REPEAT  = 2;
  localparam int EV_COUNT   = 3;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One button channel: two-flop synchronizer, tick-sampled stability
// filter and hold-to-repeat counter.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   tick       : one-cycle sample strobe shared by all channels
//   btn_in     : raw asynchronous button input
//   level      : debounced level
//   events     : registered one-cycle pulses, indexed by EV_PRESS/EV_RELEASE/EV_REPEAT
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                btn_in,
  output logic                level,
  output logic [EV_COUNT-1:0] events
);

  localparam int SW       = cnt_width(STABLE_TICKS);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW       = cnt_width(HOLD_MAX);

  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  logic          sync_meta;
  logic          sync;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic          first;

  logic differ;
  logic flip;
  logic hold_last;
  logic fire_repeat;

  // The level flips on the tick that sees the STABLE_TICKS-th consecutive
  // differing sample. A repeat is due when the hold counter reaches the
  // delay (first repeat) or the rate (later repeats); it is suppressed on a
  // tick that also flips the level, so it never overlaps press or release.
  always_comb begin
    differ      = (sync != level);
    flip        = tick && differ && (stab_cnt == STAB_LAST);
    hold_last   = first ? (hold_cnt == DELAY_LAST) : (hold_cnt == RATE_LAST);
    fire_repeat = (REPEAT_EN != 0) && tick && level && !flip && hold_last;
  end

  // Synchronizer runs every clock, independent of the sample tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync      <= sync_meta;
    end
  end

  // Stability filter: any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      level    <= 1'b0;
      stab_cnt <= '0;
    end else if (tick) begin
      if (!differ) begin
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        level    <= sync;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Hold counter wraps at its terminal value even with repeat disabled,
  // so it never runs past the largest interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      first    <= 1'b0;
    end else if (tick) begin
      if (flip) begin
        hold_cnt <= '0;
        first    <= sync;
      end else if (!level) begin
        hold_cnt <= '0;
      end else if (hold_last) begin
        hold_cnt <= '0;
        first    <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Event pulses are registered so they line up with the level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      events <= '0;
    end else begin
      events             <= '0;
      events[EV_PRESS]   <= flip && sync;
      events[EV_RELEASE] <= flip && !sync;
      events[EV_REPEAT]  <= fire_repeat;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
// Multi-channel push-button debouncer: one shared sample-tick generator
// feeding CHANNELS independent debounce_channel instances.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   btn_in      : raw asynchronous button inputs, active-high
//   btn_level   : debounced levels
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   btn_repeat  : one-cycle auto-repeat pulse while held
//   tick        : sample strobe, one cycle every CLK_DIV clocks
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 5,
  parameter int CLK_DIV      = 100,
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                tick
);

  localparam int DW = cnt_width(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]       div_cnt;
  logic [EV_COUNT-1:0] ch_events [CHANNELS];

  // Free-running divider shared by every channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Reset masks the strobe so no channel samples while being cleared.
  assign tick = !reset && (div_cnt == DIV_LAST);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .btn_in (btn_in[gi]),
      .level  (btn_level[gi]),
      .events (ch_events[gi])
    );

    assign btn_press[gi]   = ch_events[gi][EV_PRESS];
    assign btn_release[gi] = ch_events[gi][EV_RELEASE];
    assign btn_repeat[gi]  = ch_events[gi][EV_REPEAT];
  end

endmodule
